// File: rtl/alu8_pkg.sv
// Shared definitions for the ALU8 command sequencer: mode codes, FSM states, command payload.
package alu8_pkg;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_AND = 2'd2;
  localparam logic [1:0] MODE_OR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    OUT   = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] left;
    logic [7:0] right;
    logic [1:0] mode;
  } alu_cmd_t;

endpackage

// File: rtl/alu8.sv
// ALU8: combinational 8-bit datapath, wrapping ADD/SUB plus bitwise AND/OR.
module alu8
  import alu8_pkg::*;
(
  input  logic [7:0] left,
  input  logic [7:0] right,
  input  logic [1:0] mode,
  output logic [7:0] aluout_c
);

  // Select the operation; arithmetic wraps at 8 bits with no carry/borrow out.
  always_comb begin
    aluout_c = left | right;
    case (mode)
      MODE_ADD: aluout_c = left + right;
      MODE_SUB: aluout_c = left - right;
      MODE_AND: aluout_c = left & right;
      MODE_OR:  aluout_c = left | right;
      default:  aluout_c = left | right;
    endcase
  end

endmodule

// File: rtl/alu8_cmd_sequencer.sv
// Flow-controlled front end for ALU8: command FIFO, op/result registers, tagged in-order results.
module alu8_cmd_sequencer
  import alu8_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_left,
  input  logic [7:0]                   cmd_right,
  input  logic [1:0]                   cmd_mode,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [7:0]                   res_data,
  output logic [1:0]                   res_mode,
  output logic [TAG_W-1:0]             res_tag,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  alu_cmd_t         fifo_cmd [FIFO_DEPTH];
  logic [TAG_W-1:0] fifo_tag [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [TAG_W-1:0] tag_cnt;

  state_t           state;
  state_t           state_next;
  logic             push;
  logic             pop;
  logic             res_load;
  logic             res_clear;
  logic             fifo_empty;
  logic             fifo_full;

  alu_cmd_t         op_cmd;
  logic [TAG_W-1:0] op_tag;
  logic [7:0]       aluout_c;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign cmd_ready  = rst_n && !fifo_full;
  assign push       = cmd_valid && cmd_ready;
  assign busy       = !fifo_empty || (state != IDLE);
  assign fifo_count = count;

  // FIFO storage; contents need no reset since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cmd[wr_ptr] <= '{left: cmd_left, right: cmd_right, mode: cmd_mode};
      fifo_tag[wr_ptr] <= tag_cnt;
    end
  end

  // FIFO pointers, occupancy and the sequence tag counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        tag_cnt <= tag_cnt + TAG_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control strobes; a consumed result drops res_valid so ISSUE never re-offers it.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    res_load   = 1'b0;
    res_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        res_load   = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (res_ready) begin
          res_clear = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand registers feeding ALU8, loaded on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cmd <= '0;
      op_tag <= '0;
    end else if (pop) begin
      op_cmd <= fifo_cmd[rd_ptr];
      op_tag <= fifo_tag[rd_ptr];
    end
  end

  alu8 u_alu8 (
    .left     (op_cmd.left),
    .right    (op_cmd.right),
    .mode     (op_cmd.mode),
    .aluout_c (aluout_c)
  );

  // Result registers: captured on entry to OUT, held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_mode  <= '0;
      res_tag   <= '0;
    end else if (res_load) begin
      res_valid <= 1'b1;
      res_data  <= aluout_c;
      res_mode  <= op_cmd.mode;
      res_tag   <= op_tag;
    end else if (res_clear) begin
      res_valid <= 1'b0;
    end
  end

endmodule
